// File: rtl/game_pkg.sv
// Shared state encoding and default timing constants for the game countdown timer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_OVER
    } state_t;

    localparam int DEF_CLK_HZ          = 100_000_000;
    localparam int DEF_START_SECONDS   = 30;
    localparam int DEF_MAX_SECONDS     = 99;
    localparam int DEF_BONUS_SECONDS   = 2;
    localparam int DEF_PENALTY_SECONDS = 3;
    localparam int DEF_WARN_SECONDS    = 5;

    // A game is "live" while the clock is either counting or frozen by pause.
    function automatic logic is_live(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/game_timer_tick_gen.sv
// Prescaler for the game timer: counts 0..CLK_HZ-1 while enabled and flags the last count.
module tick_gen
    import game_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int               CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Terminal-count flag only; the parent gates it with its own enable.
    assign o_tick = (count == LAST);

endmodule

// File: rtl/game_timer.sv
// Game countdown timer: restart/pause control, saturating bonus/penalty arithmetic,
// low-time warning and game-over detection, all outputs registered.
module game_timer
    import game_pkg::*;
#(
    parameter int  CLK_HZ          = DEF_CLK_HZ,
    parameter int  START_SECONDS   = DEF_START_SECONDS,
    parameter int  MAX_SECONDS     = DEF_MAX_SECONDS,
    parameter int  BONUS_SECONDS   = DEF_BONUS_SECONDS,
    parameter int  PENALTY_SECONDS = DEF_PENALTY_SECONDS,
    parameter int  WARN_SECONDS    = DEF_WARN_SECONDS,
    localparam int SEC_W           = $clog2(MAX_SECONDS + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_restart_game,
    input  logic             i_pause,
    input  logic             i_add_time,
    input  logic             i_sub_time,
    output logic [SEC_W-1:0] o_seconds,
    output logic             o_tick,
    output logic             o_warning,
    output logic             o_running,
    output logic             o_game_over
);

    localparam int                      SUM_W     = SEC_W + 2;
    localparam logic [SEC_W-1:0]        START_V   = SEC_W'(START_SECONDS);
    localparam logic [SEC_W-1:0]        MAX_V     = SEC_W'(MAX_SECONDS);
    localparam logic signed [SUM_W-1:0] MAX_S     = SUM_W'(MAX_SECONDS);
    localparam logic signed [SUM_W-1:0] BONUS_S   = SUM_W'(BONUS_SECONDS);
    localparam logic signed [SUM_W-1:0] PENALTY_S = SUM_W'(PENALTY_SECONDS);
    localparam logic signed [SUM_W-1:0] ONE_S     = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ZERO_S    = '0;

    if (START_SECONDS < 1 || START_SECONDS > MAX_SECONDS || CLK_HZ < 2) begin : g_bad_params
        $error("game_timer: need 1 <= START_SECONDS <= MAX_SECONDS and CLK_HZ >= 2");
    end

    state_t                  state;
    state_t                  state_next;
    logic [SEC_W-1:0]        sec_next;
    logic                    tick_next;
    logic                    pre_clear;
    logic                    pre_enable;
    logic                    pre_last;
    logic signed [SUM_W-1:0] cur_s;
    logic signed [SUM_W-1:0] sum;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (pre_clear),
        .i_enable (pre_enable),
        .o_tick   (pre_last)
    );

    assign cur_s = $signed({2'b00, o_seconds});

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        sec_next   = o_seconds;
        tick_next  = 1'b0;
        pre_clear  = 1'b0;
        pre_enable = 1'b0;
        sum        = cur_s;

        if (i_restart_game) begin
            state_next = ST_RUN;
            sec_next   = START_V;
            pre_clear  = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (i_pause) begin
                        state_next = ST_PAUSED;
                    end else begin
                        pre_enable = 1'b1;
                        tick_next  = pre_last;
                        sum = cur_s
                            - (pre_last   ? ONE_S     : ZERO_S)
                            + (i_add_time ? BONUS_S   : ZERO_S)
                            - (i_sub_time ? PENALTY_S : ZERO_S);
                        if (sum[SUM_W-1]) begin
                            sec_next = '0;
                        end else if (sum > MAX_S) begin
                            sec_next = MAX_V;
                        end else begin
                            sec_next = sum[SEC_W-1:0];
                        end
                        if (sec_next == '0) begin
                            state_next = ST_OVER;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!i_pause) begin
                        state_next = ST_RUN;
                    end
                end
                // IDLE and OVER wait for a restart; time requests are dropped.
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_seconds   <= START_V;
            o_tick      <= 1'b0;
            o_warning   <= 1'b0;
            o_running   <= 1'b0;
            o_game_over <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state       <= state_next;
            o_seconds   <= sec_next;
            o_tick      <= tick_next;
            o_warning   <= is_live(state_next) && (sec_next != '0)
                           && (int'(sec_next) <= WARN_SECONDS);
            o_running   <= (state_next == ST_RUN);
            o_game_over <= (state_next == ST_OVER);
        end
    end

endmodule
